// File: rtl/fp16_unpack_pipelined.sv
// fp16_unpack_pipelined: binary16 operand unpacker with a 2-stage valid/ready pipeline.
// Define FP16_UNPACK_DAZ_EN for denormals-are-zero (subnormals flushed, no LZC/shifter).
module fp16_unpack_pipelined #(
  parameter int EXP_W = 7,
  parameter int BIAS  = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [15:0]             in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sign,
  output logic signed [EXP_W-1:0] out_exp,
  output logic [10:0]             out_mant,
  output logic                    out_zero,
  output logic                    out_sub,
  output logic                    out_inf,
  output logic                    out_nan
);

  typedef enum logic [2:0] {CLS_NORM, CLS_ZERO, CLS_SUB, CLS_INF, CLS_NAN} cls_e;

  logic        vld_p1, vld_p2;
  logic        load_p2, adv_p1, acc_p0;
  logic        sign_p1;
  logic [4:0]  exp_p1;
  logic [9:0]  frac_p1;
  cls_e        cls_p1;

  function automatic cls_e classify(input logic [4:0] e, input logic [9:0] f);
    if (e == 5'd31) return (f == '0) ? CLS_INF : CLS_NAN;
    if (e == 5'd0)  return (f == '0) ? CLS_ZERO : CLS_SUB;
    return CLS_NORM;
  endfunction

  function automatic logic signed [EXP_W-1:0] unbias(input logic [4:0] e);
    return EXP_W'(e) - EXP_W'(BIAS);
  endfunction

`ifndef FP16_UNPACK_DAZ_EN
  logic [3:0] lz_p1;

  // Highest set bit wins; an all-zero fraction never reaches the shifter.
  function automatic logic [3:0] lzc10(input logic [9:0] f);
    logic [3:0] n;
    n = 4'd9;
    for (int i = 0; i < 10; i++)
      if (f[i]) n = 4'(9 - i);
    return n;
  endfunction

  function automatic logic [10:0] norm_mant(input logic [9:0] f, input logic [3:0] lz);
    logic [10:0] m;
    m = {f, 1'b0};
    return m << lz;
  endfunction

  function automatic logic signed [EXP_W-1:0] sub_exp(input logic [3:0] lz);
    return -EXP_W'(BIAS) - EXP_W'(lz);
  endfunction
`endif

  assign load_p2   = !vld_p2 || out_ready;
  assign adv_p1    = vld_p1 && load_p2;
  assign in_ready  = !vld_p1 || adv_p1;
  assign acc_p0    = in_valid && in_ready;
  assign out_valid = vld_p2;

  // Stage 1: field split, classification, leading-zero count
  always_ff @(posedge clk) begin
    if (rst)         vld_p1 <= 1'b0;
    else if (acc_p0) vld_p1 <= 1'b1;
    else if (adv_p1) vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (acc_p0) begin
      sign_p1 <= in_data[15];
      exp_p1  <= in_data[14:10];
      frac_p1 <= in_data[9:0];
      cls_p1  <= classify(in_data[14:10], in_data[9:0]);
`ifndef FP16_UNPACK_DAZ_EN
      lz_p1   <= lzc10(in_data[9:0]);
`endif
    end
  end

  // Stage 2: normalization shift, exponent arithmetic, output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      out_sign <= 1'b0;
      out_exp  <= '0;
      out_mant <= '0;
      out_zero <= 1'b0;
      out_sub  <= 1'b0;
      out_inf  <= 1'b0;
      out_nan  <= 1'b0;
    end else if (load_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        out_sign <= sign_p1;
        out_exp  <= '0;
        out_mant <= '0;
        out_zero <= 1'b0;
        out_sub  <= 1'b0;
        out_inf  <= 1'b0;
        out_nan  <= 1'b0;
        case (cls_p1)
          CLS_NORM: begin
            out_exp  <= unbias(exp_p1);
            out_mant <= {1'b1, frac_p1};
          end
          CLS_ZERO: out_zero <= 1'b1;
          CLS_SUB: begin
`ifdef FP16_UNPACK_DAZ_EN
            out_zero <= 1'b1;
            out_sub  <= 1'b1;
`else
            out_sub  <= 1'b1;
            out_exp  <= sub_exp(lz_p1);
            out_mant <= norm_mant(frac_p1, lz_p1);
`endif
          end
          CLS_INF: out_inf <= 1'b1;
          CLS_NAN: begin
            out_nan  <= 1'b1;
            out_mant <= {1'b0, frac_p1};
          end
          default: ;
        endcase
      end
    end
  end

endmodule
